// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, MODE field positions and default divisors
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_LOAD} state_t;
    localparam int MODE_BAUD_HI  = 7;
    localparam int MODE_BAUD_LO  = 6;
    localparam int MODE_ONE_STOP = 5;
    localparam int MODE_ODD      = 1;
    localparam int MODE_PAR_EN   = 0;
    localparam int DEF_DIV0 = 10416;
    localparam int DEF_DIV1 = 5208;
    localparam int DEF_DIV2 = 2604;
    localparam int DEF_DIV3 = 868;
    function automatic int max4(input int a, input int b, input int c, input int d);
        int ab, cd;
        ab = a > b ? a : b;
        cd = c > d ? c : d;
        return ab > cd ? ab : cd;
    endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, ticks every divisor (or divisor/2) clocks
module uart_baud_cnt #(
    parameter int CW = 8
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic [CW-1:0] divisor,
    input  logic          restart,
    input  logic          half,
    output logic          tick
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    always_comb begin
        target = half ? divisor >> 1 : divisor;
        tick   = !restart && cnt == target - CW'(1);
    end
    always_ff @(posedge Clock) begin
        if (!Reset_n || restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a one-word holding register,
// parity/framing/overrun flags and a VALID/READY output handshake.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int MSB_FIRST = 1,
    parameter int DIV0 = DEF_DIV0,
    parameter int DIV1 = DEF_DIV1,
    parameter int DIV2 = DEF_DIV2,
    parameter int DIV3 = DEF_DIV3
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [7:0]           MODE,
    input  logic                 DATA_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 PAR_ERR,
    output logic                 FRM_ERR,
    output logic                 OVR_ERR,
    output logic                 RTS
);
    localparam int CW = $clog2(max4(DIV0, DIV1, DIV2, DIV3)) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    state_t               state;
    logic                 s1, s2, s3;
    logic [7:0]           mode_r;
    logic [BW-1:0]        nbit;
    logic [DATA_BITS-1:0] shreg;
    logic                 par, perr, ferr;
    logic [CW-1:0]        divisor;
    logic                 restart, half, tick, hs;

    always_comb begin
        divisor = mode_r[MODE_BAUD_HI:MODE_BAUD_LO] == 2'd0 ? CW'(DIV0) :
                  mode_r[MODE_BAUD_HI:MODE_BAUD_LO] == 2'd1 ? CW'(DIV1) :
                  mode_r[MODE_BAUD_HI:MODE_BAUD_LO] == 2'd2 ? CW'(DIV2) : CW'(DIV3);
        restart = state == S_IDLE;
        half    = state == S_START;
        hs      = VALID && READY;
    end

    assign RTS = ~VALID;

    uart_baud_cnt #(.CW(CW)) u_baud (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .divisor (divisor),
        .restart (restart),
        .half    (half),
        .tick    (tick)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            mode_r   <= '0;
            nbit     <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            PAR_ERR  <= 1'b0;
            FRM_ERR  <= 1'b0;
            OVR_ERR  <= 1'b0;
        end else begin
            s1 <= DATA_IN;
            s2 <= s1;
            s3 <= s2;
            if (hs) begin
                VALID   <= 1'b0;
                OVR_ERR <= 1'b0;
            end
            case (state)
                S_IDLE: if (s3 && !s2) begin
                    state  <= S_START;
                    mode_r <= MODE;
                    nbit   <= '0;
                    par    <= 1'b0;
                    perr   <= 1'b0;
                    ferr   <= 1'b0;
                end
                S_START: if (tick) state <= s2 ? S_IDLE : S_DATA;
                S_DATA: if (tick) begin
                    shreg <= MSB_FIRST != 0 ? {shreg[DATA_BITS-2:0], s2} : {s2, shreg[DATA_BITS-1:1]};
                    par   <= par ^ s2;
                    nbit  <= nbit + BW'(1);
                    if (nbit == BW'(DATA_BITS - 1))
                        state <= mode_r[MODE_PAR_EN] ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (tick) begin
                    perr  <= (par ^ s2) != mode_r[MODE_ODD];
                    state <= S_STOP1;
                end
                S_STOP1: if (tick) begin
                    ferr  <= !s2;
                    state <= mode_r[MODE_ONE_STOP] ? S_LOAD : S_STOP2;
                end
                S_STOP2: if (tick) begin
                    ferr  <= ferr | !s2;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    state <= S_IDLE;
                    // a full register that is not being emptied this edge keeps its word
                    if (!VALID || READY) begin
                        DATA_OUT <= shreg;
                        PAR_ERR  <= perr;
                        FRM_ERR  <= ferr;
                        VALID    <= 1'b1;
                    end else
                        OVR_ERR <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg; expected words are queued
// as frames are sent and compared at each VALID/READY handshake.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] MODE = 8'hE0;
    logic       DATA_IN = 1'b1;
    logic [7:0] DATA_OUT;
    logic       VALID, READY = 1'b1, PAR_ERR, FRM_ERR, OVR_ERR, RTS;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vcyc = 0;
    int   v0;

    uart_rx_cfg #(.DIV0(40), .DIV1(32), .DIV2(24), .DIV3(16)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .MODE     (MODE),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .READY    (READY),
        .PAR_ERR  (PAR_ERR),
        .FRM_ERR  (FRM_ERR),
        .OVR_ERR  (OVR_ERR),
        .RTS      (RTS)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset_n) begin
            if (VALID) vcyc++;
            if (VALID && READY) begin
                if (sb.size() == 0)
                    check("unexpected_word", {24'b0, DATA_OUT}, 32'hFFFF_FFFF);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data", {24'b0, DATA_OUT}, {24'b0, e.d});
                    check("par_err", {31'b0, PAR_ERR}, {31'b0, e.pe});
                    check("frm_err", {31'b0, FRM_ERR}, {31'b0, e.fe});
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input int div);
        DATA_IN = b;
        repeat (div) @(posedge Clock);
        #1;
    endtask

    task automatic gap(input int bits, input int div);
        DATA_IN = 1'b1;
        repeat (bits * div) @(posedge Clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic two_stop, input logic stop2, input int div);
        @(posedge Clock);
        #1;
        drive_bit(1'b0, div);
        for (int i = 7; i >= 0; i--) drive_bit(d[i], div);
        if (par_en) drive_bit(par_bit, div);
        drive_bit(1'b1, div);
        if (two_stop) drive_bit(stop2, div);
        DATA_IN = 1'b1;
    endtask

    initial begin
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("rst_valid", {31'b0, VALID}, 0);
        check("rst_rts", {31'b0, RTS}, 1);
        check("rst_data", {24'b0, DATA_OUT}, 0);
        check("rst_ovr", {31'b0, OVR_ERR}, 0);
        check("rst_par", {31'b0, PAR_ERR}, 0);
        check("rst_frm", {31'b0, FRM_ERR}, 0);
        check("rst_state", {29'b0, dut.state}, {29'b0, S_IDLE});
        Reset_n = 1'b1;
        gap(2, 16);

        MODE = 8'hE0;
        push(8'hA5, 0, 0);
        v0 = vcyc;
        send_frame(8'hA5, 0, 0, 0, 0, 16);
        gap(4, 16);
        check("a5_valid_1cyc", vcyc - v0, 1);

        MODE = 8'hE1;
        push(8'h3C, 1, 0);
        send_frame(8'h3C, 1, 1, 0, 0, 16);
        gap(4, 16);

        MODE = 8'hE3;
        push(8'h3C, 0, 0);
        send_frame(8'h3C, 1, 1, 0, 0, 16);
        gap(4, 16);

        MODE = 8'hE0;
        v0 = vcyc;
        DATA_IN = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        gap(3, 16);
        check("glitch_no_valid", vcyc - v0, 0);
        check("glitch_idle", {29'b0, dut.state}, {29'b0, S_IDLE});
        check("glitch_rts", {31'b0, RTS}, 1);

        MODE = 8'hC0;
        push(8'h81, 0, 1);
        send_frame(8'h81, 0, 0, 1, 0, 16);
        gap(4, 16);

        // one stop bit: the low second stop bit reads as a fresh start of an all-ones word
        MODE = 8'hE0;
        push(8'h81, 0, 0);
        push(8'hFF, 0, 0);
        send_frame(8'h81, 0, 0, 1, 0, 16);
        gap(12, 16);

        MODE = 8'h20;
        push(8'h6E, 0, 0);
        send_frame(8'h6E, 0, 0, 0, 0, 40);
        gap(4, 40);

        MODE = 8'hE0;
        READY = 1'b0;
        push(8'h11, 0, 0);
        send_frame(8'h11, 0, 0, 0, 0, 16);
        gap(4, 16);
        send_frame(8'h22, 0, 0, 0, 0, 16);
        gap(4, 16);
        check("ovr_data", {24'b0, DATA_OUT}, 32'h11);
        check("ovr_valid", {31'b0, VALID}, 1);
        check("ovr_flag", {31'b0, OVR_ERR}, 1);
        check("ovr_rts", {31'b0, RTS}, 0);
        READY = 1'b1;
        @(posedge Clock);
        #1;
        check("hs_valid", {31'b0, VALID}, 0);
        check("hs_ovr", {31'b0, OVR_ERR}, 0);
        check("hs_rts", {31'b0, RTS}, 1);
        gap(2, 16);

        v0 = vcyc;
        @(posedge Clock);
        #1;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        DATA_IN = 1'b0;
        repeat (8) @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        DATA_IN = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("midrst_idle", {29'b0, dut.state}, {29'b0, S_IDLE});
        Reset_n = 1'b1;
        gap(12, 16);
        check("midrst_no_valid", vcyc - v0, 0);
        push(8'h5A, 0, 0);
        send_frame(8'h5A, 0, 0, 0, 0, 16);
        gap(4, 16);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
